// File: rtl/ascon_round_sequencer_pkg.sv
// Shared types and round-count constants for the ASCON round sequencer.
// Optional round-index checker is enabled with ASCON_SEQ_CPT_CHECK_EN.
package ascon_pack;

  localparam int NB_ROUNDS_A = 12;
  localparam int NB_ROUNDS_B = 6;

  localparam logic [3:0] CPT_PRELOAD_B = 4'(NB_ROUNDS_A - NB_ROUNDS_B);
  localparam logic [3:0] CPT_LAST      = 4'(NB_ROUNDS_A - 1);

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_LOAD,
    SEQ_RUN,
    SEQ_DONE
  } seq_state_t;

endpackage

// File: rtl/ascon_round_sequencer.sv
// Sequences one p12/p6 ASCON permutation per request over an external round counter.
// Define ASCON_SEQ_CPT_CHECK_EN to add a shadow counter that flags round-index mismatches.
module ascon_round_sequencer
  import ascon_pack::*;
#(
  parameter int NB_ROUNDS_A = ascon_pack::NB_ROUNDS_A,
  parameter int NB_ROUNDS_B = ascon_pack::NB_ROUNDS_B
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       mode_i,
  input  logic       pause_i,
  input  logic [3:0] cpt_i,
  output logic       en_round_o,
  output logic       init_a_o,
  output logic       init_b_o,
  output logic       round_valid_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       cpt_err_o
);

  localparam logic [3:0] LAST    = 4'(NB_ROUNDS_A - 1);
  localparam logic [3:0] PRELOAD = 4'(NB_ROUNDS_A - NB_ROUNDS_B);

  seq_state_t state_q, state_d;
  logic       mode_q, mode_d;

  logic en_round;
  logic init_a;
  logic init_b;
  logic round_valid;
  logic busy;
  logic done;

  // Outputs decode from the state register only; start_i never reaches them.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    en_round    = 1'b0;
    init_a      = 1'b0;
    init_b      = 1'b0;
    round_valid = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (start_i) begin
          mode_d  = mode_i;
          state_d = SEQ_LOAD;
        end
      end
      SEQ_LOAD: begin
        busy     = 1'b1;
        en_round = 1'b1;
        init_a   = ~mode_q;
        init_b   = mode_q;
        state_d  = SEQ_RUN;
      end
      SEQ_RUN: begin
        busy        = 1'b1;
        round_valid = ~pause_i;
        if (cpt_i != LAST) begin
          en_round = ~pause_i;
        end else if (!pause_i) begin
          state_d = SEQ_DONE;
        end
      end
      SEQ_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= SEQ_IDLE;
    end else begin
      state_q <= state_d;
    end
    mode_q <= mode_d;
  end

  assign en_round_o    = en_round;
  assign init_a_o      = init_a;
  assign init_b_o      = init_b;
  assign round_valid_o = round_valid;
  assign busy_o        = busy;
  assign done_o        = done;

`ifdef ASCON_SEQ_CPT_CHECK_EN
  logic [3:0] shadow_q, shadow_d;
  logic       cpt_err_q, cpt_err_d;

  // Shadow tracks the index the counter should present on each applied round.
  always_comb begin
    shadow_d  = shadow_q;
    cpt_err_d = cpt_err_q;
    if (state_q == SEQ_IDLE && start_i) begin
      cpt_err_d = 1'b0;
    end
    if (state_q == SEQ_LOAD) begin
      shadow_d = mode_q ? PRELOAD : 4'd0;
    end
    if (round_valid) begin
      if (cpt_i != shadow_q) begin
        cpt_err_d = 1'b1;
      end
      shadow_d = shadow_q + 4'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cpt_err_q <= 1'b0;
    end else begin
      cpt_err_q <= cpt_err_d;
    end
    shadow_q <= shadow_d;
  end

  assign cpt_err_o = cpt_err_q;
`else
  assign cpt_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Bench for ascon_round_sequencer with an attached round-counter model.
// Checks the mismatch flag when built with ASCON_SEQ_CPT_CHECK_EN.
module tb_ascon_round_sequencer;
  import ascon_pack::*;

`ifdef ASCON_SEQ_CPT_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic       mode_i  = 1'b0;
  logic       pause_i = 1'b0;
  logic [3:0] cpt_i;
  logic       en_round_o, init_a_o, init_b_o, round_valid_o, busy_o, done_o, cpt_err_o;

  ascon_round_sequencer dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .pause_i      (pause_i),
    .cpt_i        (cpt_i),
    .en_round_o   (en_round_o),
    .init_a_o     (init_a_o),
    .init_b_o     (init_b_o),
    .round_valid_o(round_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .cpt_err_o    (cpt_err_o)
  );

  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  // Round counter model; skip3 makes it jump 2 -> 4.
  logic [3:0] cnt_q = 4'd0;
  bit skip3 = 1'b0;
  assign cpt_i = cnt_q;
  always @(posedge clock_i) begin
    if (reset_i) cnt_q <= 4'd0;
    else if (en_round_o) begin
      if (init_a_o)                    cnt_q <= 4'd0;
      else if (init_b_o)               cnt_q <= 4'd6;
      else if (skip3 && cnt_q == 4'd2) cnt_q <= 4'd4;
      else                             cnt_q <= cnt_q + 4'd1;
    end
  end

  typedef struct {
    int start_cyc;
    bit mode;
    int lat;
    int rounds;
    int first;
  } exp_t;

  typedef struct {
    bit mode;
    int pause_cpt;
    int pause_len;
    int lat;
    int rounds;
    int first;
  } vec_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  int m_rounds = 0;
  int m_first  = 0;
  int m_last   = 0;

  always begin
    @(negedge clock_i);
    #1;
    if (reset_i) begin
      m_rounds = 0;
    end else begin
      if (en_round_o && (init_a_o || init_b_o)) begin
        chk("init_exclusive", int'(init_a_o & init_b_o), 0);
        if (sb.size() == 0) chk("load_unexpected", 1, 0);
        else begin
          chk("load_cycle", cyc, sb[0].start_cyc + 1);
          chk("init_a", int'(init_a_o), int'(!sb[0].mode));
          chk("init_b", int'(init_b_o), int'(sb[0].mode));
        end
        m_rounds = 0;
      end
      if (pause_i) begin
        chk("pause_en_round", int'(en_round_o), 0);
        chk("pause_round_valid", int'(round_valid_o), 0);
      end
      if (round_valid_o) begin
        if (m_rounds == 0) m_first = int'(cpt_i);
        m_last = int'(cpt_i);
        m_rounds++;
      end
      if (done_o) begin
        n_done++;
        if (sb.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_latency", cyc - e.start_cyc, e.lat);
          chk("round_count", m_rounds, e.rounds);
          chk("first_cpt", m_first, e.first);
          chk("last_cpt", m_last, 11);
          chk("done_busy", int'(busy_o), 1);
        end
      end
    end
  end

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock_i);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk(name, 0, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int left;
    bit seen;
    @(negedge clock_i);
    start_i = 1'b1;
    mode_i  = v.mode;
    sb.push_back('{cyc, v.mode, v.lat, v.rounds, v.first});
    left = v.pause_len;
    seen = 1'b0;
    @(negedge clock_i);
    start_i = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock_i);
      if (done_o) begin
        pause_i = 1'b0;
        seen = 1'b1;
        break;
      end
      pause_i = (left > 0) && (int'(cpt_i) == v.pause_cpt);
      if (pause_i) left--;
    end
    if (!seen) chk("run_timeout", 0, 1);
  endtask

  vec_t vecs[6];

  initial begin
    int s;
    int d0;
    vecs[0] = '{1'b0, -1, 0, 14, 12, 0};
    vecs[1] = '{1'b1, -1, 0,  8,  6, 6};
    vecs[2] = '{1'b0,  4, 3, 17, 12, 0};
    vecs[3] = '{1'b1,  8, 2, 10,  6, 6};
    vecs[4] = '{1'b0, 11, 1, 15, 12, 0};
    vecs[5] = '{1'b1,  6, 1,  9,  6, 6};

    // Reset state
    repeat (3) @(negedge clock_i);
    #1;
    chk("reset_outputs",
        int'({en_round_o, init_a_o, init_b_o, round_valid_o, busy_o, done_o, cpt_err_o}), 0);
    reset_i = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);
    chk("no_err_clean_runs", int'(cpt_err_o), 0);

    // start held high through a p6 run: DONE ignores it, IDLE re-samples it
    @(negedge clock_i);
    start_i = 1'b1;
    mode_i  = 1'b1;
    s = cyc;
    sb.push_back('{s, 1'b1, 8, 6, 6});
    repeat (9) @(negedge clock_i);
    #1;
    chk("held_start_idle_busy", int'(busy_o), 0);
    sb.push_back('{s + 9, 1'b1, 8, 6, 6});
    @(negedge clock_i);
    start_i = 1'b0;
    wait_done("held_start_second_done");

    // Reset mid-run at cpt 5 of p12
    @(negedge clock_i);
    start_i = 1'b1;
    mode_i  = 1'b0;
    sb.push_back('{cyc, 1'b0, 14, 12, 0});
    @(negedge clock_i);
    start_i = 1'b0;
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clock_i);
        if (round_valid_o && cpt_i == 4'd5) begin
          hit = 1'b1;
          break;
        end
      end
      chk("reach_cpt5", int'(hit), 1);
    end
    reset_i = 1'b1;
    sb.delete();
    d0 = n_done;
    @(negedge clock_i);
    reset_i = 1'b0;
    #1;
    chk("abort_outputs",
        int'({en_round_o, init_a_o, init_b_o, round_valid_o, busy_o, done_o, cpt_err_o}), 0);
    repeat (20) @(negedge clock_i);
    chk("abort_no_done", n_done - d0, 0);

    // Counter skips index 3; the checker build must flag it
    skip3 = 1'b1;
    run_vec('{1'b0, -1, 0, 13, 11, 0});
    chk("err_at_done", int'(cpt_err_o), CHK);
    skip3 = 1'b0;
    @(negedge clock_i);
    #1;
    chk("err_sticky_idle", int'(cpt_err_o), CHK);
    start_i = 1'b1;
    mode_i  = 1'b1;
    sb.push_back('{cyc, 1'b1, 8, 6, 6});
    @(negedge clock_i);
    start_i = 1'b0;
    #1;
    chk("err_cleared_on_start", int'(cpt_err_o), 0);
    wait_done("post_err_done");
    @(negedge clock_i);
    #1;
    chk("err_clean_run", int'(cpt_err_o), 0);

    repeat (3) @(negedge clock_i);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
